sprite_mover: RTL and testbench
===============================

Name: sprite_mover

Overview:
- Parametrised lane-sprite animator for the VGA street-crossing game.
- On each step request it performs four actions in order:
  - erases an SPR_W x SPR_H box at the current position;
  - moves the origin left or right by a run-time step with wrap-around inside [X_MIN, X_MAX];
  - redraws the box in the requested colour;
  - holds for a frame delay.
- Sits between the game controller (which issues step requests and arbitrates VGA plot access) and the VGA adapter pixel port.
- One instance per car or log lane.

Parameters:
- SPR_W, 8, sprite width in pixels (1..16).
- SPR_H, 4, sprite height in pixels (1..8).
- X_START, 102, origin x after reset.
- Y_START, 27, fixed origin y (lane row).
- X_MIN, 26, lowest legal origin x.
- X_MAX, 127, highest legal origin x.
- DELAY_CYCLES, 8334, clocks per frame tick.
- FRAMES, 2, frame ticks held after each draw.

Ports:
- clk, input, 1, system clock.
- resetn, input, 1, reset. Synchronous, active-low.
- en, input, 1, step request. Sampled only in IDLE.
- dir, input, 1, direction: 0 = right (+x), 1 = left (-x). Latched on accept.
- step, input, 4, pixels moved per request. Latched on accept.
- colour, input, 3, draw colour. Latched on accept.
- plot, output, 1, pixel write strobe to VGA.
- x, output, 8, pixel x.
- y, output, 7, pixel y.
- colour_out, output, 3, pixel colour.
- x_ori, output, 8, current sprite origin x (used by collision logic).
- busy, output, 1, high whenever state != IDLE.
- done, output, 1, single-cycle pulse when a request completes.

Behaviour:
- Reset values (next edge with resetn=0, from any state including mid-operation):
  - state=IDLE; x_ori=X_START; plot=0; colour_out=0; x=X_START; y=Y_START; busy=0; done=0.
  - All counters are cleared.
- States and transitions:
  - IDLE: en=1 latches dir, step and colour; next state is ERASE.
  - ERASE: pixel counter p runs 0..SPR_W*SPR_H-1, one pixel per cycle. plot=1, colour_out=0. After the last pixel, go to MOVE.
  - MOVE: one cycle, plot=0. x_ori is updated at the end of this cycle. Go to DRAW.
  - DRAW: same scan as ERASE with colour_out = latched colour. After the last pixel, go to HOLD.
  - HOLD: plot=0. Counts DELAY_CYCLES*FRAMES cycles. In the last HOLD cycle done=1, and the next state is IDLE.
- Pixel scan is raster order, column fastest:
  - col = p mod SPR_W; row = p div SPR_W.
  - x = x_ori + col (8-bit, modulo 256); y = Y_START + row.
- Outputs plot, x, y and colour_out are combinational from registered state and counters; they are valid in the same cycle as plot.
- Outside ERASE/DRAW: x=x_ori, y=Y_START, colour_out=0.
- Move arithmetic is computed at 9 bits, with s = latched step:
  - Right: if x_ori+s > X_MAX then x_ori <= X_MIN + (x_ori+s-X_MAX-1), else x_ori <= x_ori+s.
  - Left: if x_ori < X_MIN+s then x_ori <= X_MAX - (X_MIN+s-x_ori-1), else x_ori <= x_ori-s.
  - s=0: x_ori is unchanged, but the full erase/draw/hold sequence still runs.
  - Legal s is 0..(X_MAX-X_MIN). Larger values are a usage error and the result is unspecified.
- Latency: accept-to-done = 2*SPR_W*SPR_H + 1 + DELAY_CYCLES*FRAMES cycles after the IDLE accept cycle.
- en is ignored while busy. No queuing.
- en high in the cycle after done: the request is accepted immediately (back-to-back operation).
- dir, step and colour changes while busy have no effect.

Optional Feature:
- Macro SPRITE_CLIP_EN.
- Defined: during ERASE/DRAW, pixels with x_ori+col > X_MAX have plot forced to 0, so the sprite clips at the road edge. Cycle count is unchanged.
- Not defined: all SPR_W*SPR_H pixels are plotted, and x wraps modulo 256.

Test Plan:
All tests use DELAY_CYCLES=4 and FRAMES=2; every other parameter is at its default.
- Reset, then hold resetn=1 with en=0 for 10 cycles -> plot=0, x_ori=102, x=102, y=27, busy=0, done=0 throughout.
- en pulse with dir=0, step=1, colour=3'b101:
  - 32 ERASE cycles with plot=1, colour_out=0, x 102..109, y 27..30;
  - 1 MOVE cycle with plot=0;
  - 32 DRAW cycles with x 103..110, colour_out=101;
  - 8 HOLD cycles, with done high only in the last one. Total 73 cycles; x_ori=103.
- Right wrap: x_ori=126, dir=0, step=3 -> x_ori=27. Left wrap: x_ori=27, dir=1, step=3 -> x_ori=126.
- Assert resetn=0 for one cycle at DRAW pixel 10 -> next cycle IDLE, plot=0, x_ori=102, busy=0. A following en runs a complete sequence.
- en held high continuously, step=0 -> back-to-back 73-cycle sequences with an IDLE accept cycle between them. x_ori is unchanged and done pulses once per sequence.
- With SPRITE_CLIP_EN and x_ori=124, DRAW -> plot=1 only for col 0..3 (x 124..127). Cycle count is still 32.

Source files
------------

// File: rtl/sprite_mover.sv
// Lane sprite animator: erase box, move origin with wrap inside [X_MIN, X_MAX], redraw, hold.
// Optional build macro SPRITE_CLIP_EN suppresses plot for pixels right of X_MAX.
module sprite_mover #(
  parameter int SPR_W        = 8,
  parameter int SPR_H        = 4,
  parameter int X_START      = 102,
  parameter int Y_START      = 27,
  parameter int X_MIN        = 26,
  parameter int X_MAX        = 127,
  parameter int DELAY_CYCLES = 8334,
  parameter int FRAMES       = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       dir,
  input  logic [3:0] step,
  input  logic [2:0] colour,
  output logic       plot,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour_out,
  output logic [7:0] x_ori,
  output logic       busy,
  output logic       done
);

  localparam int HOLD_N = DELAY_CYCLES * FRAMES;
  localparam int CW     = $clog2(SPR_W + 1);
  localparam int RW     = $clog2(SPR_H + 1);
  localparam int HW     = $clog2(HOLD_N + 1);

  localparam logic [CW-1:0] COL_LAST  = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(SPR_H - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_N - 1);
  localparam logic [8:0]    XMIN9     = 9'(X_MIN);
  localparam logic [8:0]    XMAX9     = 9'(X_MAX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERASE = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_DRAW  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  // Handshake: en is a request sampled only while busy=0; the request is
  // accepted on that edge, busy stays high until the cycle after the
  // single-cycle done pulse, and no requests are queued meanwhile.
  logic [2:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] hcnt;
  logic          dir_q;
  logic [3:0]    step_q;
  logic [2:0]    colour_q;

  logic       scan;
  logic       last_pix;
  logic       clip;
  logic [8:0] ori9;
  logic [8:0] s9;
  logic [8:0] sum9;
  logic [7:0] move_next;

  assign scan     = (state == S_ERASE) || (state == S_DRAW);
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_HOLD) && (hcnt == HOLD_LAST);

  // Wrap arithmetic is kept at 9 bits so x_ori + step cannot overflow.
  always_comb begin
    ori9      = {1'b0, x_ori};
    s9        = {5'd0, step_q};
    sum9      = ori9 + s9;
    move_next = x_ori;
    if (!dir_q) begin
      if (sum9 > XMAX9) move_next = 8'(XMIN9 + sum9 - XMAX9 - 9'd1);
      else              move_next = 8'(sum9);
    end else begin
      if (ori9 < XMIN9 + s9) move_next = 8'(XMAX9 - (XMIN9 + s9 - ori9 - 9'd1));
      else                   move_next = 8'(ori9 - s9);
    end
  end

`ifdef SPRITE_CLIP_EN
  logic [8:0] px9;
  assign px9  = ori9 + 9'(col);
  assign clip = (px9 > XMAX9);
`else
  assign clip = 1'b0;
`endif

  assign plot       = scan && !clip;
  assign x          = scan ? (x_ori + 8'(col)) : x_ori;
  assign y          = 7'(Y_START) + (scan ? 7'(row) : 7'd0);
  assign colour_out = (state == S_DRAW) ? colour_q : 3'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      hcnt     <= '0;
      x_ori    <= 8'(X_START);
      dir_q    <= 1'b0;
      step_q   <= 4'd0;
      colour_q <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          col  <= '0;
          row  <= '0;
          hcnt <= '0;
          if (en) begin
            dir_q    <= dir;
            step_q   <= step;
            colour_q <= colour;
            state    <= S_ERASE;
          end
        end
        S_ERASE, S_DRAW: begin
          if (last_pix) begin
            col   <= '0;
            row   <= '0;
            state <= (state == S_ERASE) ? S_MOVE : S_HOLD;
          end else if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_MOVE: begin
          x_ori <= move_next;
          state <= S_DRAW;
        end
        S_HOLD: begin
          if (hcnt == HOLD_LAST) begin
            hcnt  <= '0;
            state <= S_IDLE;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: a wrap/box model queues expected pixels, a monitor checks plots.
module tb_sprite_mover;

  localparam int SPR_W   = 8;
  localparam int SPR_H   = 4;
  localparam int X_START = 102;
  localparam int Y_START = 27;
  localparam int X_MIN   = 26;
  localparam int X_MAX   = 127;
  localparam int DLY     = 4;
  localparam int FRM     = 2;
  localparam int SEQ_LEN = 2 * SPR_W * SPR_H + 1 + DLY * FRM;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] step = 4'd0;
  logic [2:0] colour = 3'd0;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour_out;
  logic [7:0] x_ori;
  logic       busy;
  logic       done;

  sprite_mover #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .X_START(X_START), .Y_START(Y_START),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .DELAY_CYCLES(DLY), .FRAMES(FRM)
  ) dut (
    .clk(clk), .resetn(resetn), .en(en), .dir(dir), .step(step), .colour(colour),
    .plot(plot), .x(x), .y(y), .colour_out(colour_out), .x_ori(x_ori),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [17:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  int done_seen = 0;
  int done_exp  = 0;
  int model_x   = X_START;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Origin moves around a ring of X_MAX-X_MIN+1 legal positions.
  function automatic int next_x(input int xo, input bit d, input int s);
    int r;
    r = X_MAX - X_MIN + 1;
    if (!d) return X_MIN + (xo - X_MIN + s) % r;
    return X_MIN + (((xo - X_MIN - s) % r) + r) % r;
  endfunction

  task automatic push_box(input int ox, input logic [2:0] c);
    int px;
    for (int r = 0; r < SPR_H; r++) begin
      for (int cl = 0; cl < SPR_W; cl++) begin
        px = ox + cl;
`ifdef SPRITE_CLIP_EN
        if (px > X_MAX) continue;
`endif
        exp_q.push_back({8'(px), 7'(Y_START + r), c});
      end
    end
  endtask

  // Monitor: every plotted pixel must match the head of the expected queue.
  always @(negedge clk) begin
    logic [17:0] e;
    logic [17:0] got;
    if (done) done_seen++;
    if (plot) begin
      got = {x, y, colour_out};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got x=%0d y=%0d c=%0d expected none", x, y, colour_out);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   x, y, colour_out, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  // Called at a negedge while idle; abort_at>0 pulses reset at that cycle after accept.
  task automatic issue(input bit d, input int s, input logic [2:0] c,
                       input bit keep_en, input int abort_at);
    int k;
    int nx;
    bit seen;
    dir    = d;
    step   = 4'(s);
    colour = c;
    en     = 1'b1;
    nx     = next_x(model_x, d, s);
    push_box(model_x, 3'd0);
    push_box(nx, c);
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      k++;
      if (!keep_en) en = 1'b0;
      if (abort_at == k) begin
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("abort_plot", plot, 0);
        check("abort_x_ori", x_ori, X_START);
        check("abort_busy", busy, 0);
        check("abort_x", x, X_START);
        exp_q.delete();
        model_x = X_START;
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done in %0d cycles expected %0d", k, SEQ_LEN);
    end else begin
      check("done_latency", k, SEQ_LEN);
      done_exp++;
    end
    model_x = nx;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("x_ori", x_ori, model_x);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_x_ori", x_ori, X_START);
    check("rst_x", x, X_START);
    check("rst_y", y, Y_START);
    check("rst_colour", colour_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_plot", plot, 0);
      check("idle_x_ori", x_ori, X_START);
      check("idle_x", x, X_START);
      check("idle_y", y, Y_START);
      check("idle_busy0", busy, 0);
      check("idle_done", done, 0);
    end

    issue(1'b0, 1, 3'b101, 1'b0, 0);
    issue(1'b0, 15, 3'd2, 1'b0, 0);
    issue(1'b0, 8, 3'd3, 1'b0, 0);
    issue(1'b0, 3, 3'd4, 1'b0, 0);
    issue(1'b1, 3, 3'd6, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, 15),
            3'($urandom_range(0, 7)), 1'b0, 0);
    end

    issue(1'b0, 5, 3'd6, 1'b0, 34 + 10);
    issue(1'b1, 2, 3'd2, 1'b0, 0);

    issue(1'b0, 11, 3'd1, 1'b0, 0);
    issue(1'b0, 13, 3'd5, 1'b0, 0);
    issue(1'b0, 0, 3'd7, 1'b0, 0);

    for (int i = 0; i < 3; i++) issue(1'b0, 0, 3'd4, 1'b1, 0);
    en = 1'b0;

    repeat (3) @(negedge clk);
    check("done_count", done_seen, done_exp);
    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
